// File: rtl/ccip_nic_transmitter.sv
// NIC-to-CPU CCI-P transmitter: writes each accepted RPC as one cache line into
// a per-flow host ring, tracking the next write slot of every flow in a small RAM.
package ccip_nic_pkg;
  localparam int LMAX_CCIP_BATCH = 4;

  typedef logic [41:0]  t_ccip_clAddr;
  typedef logic [511:0] t_ccip_clData;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [1:0] {eVC_VA, eVC_VL0, eVC_VH0, eVC_VH1} t_ccip_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'b00, eCL_LEN_2 = 2'b01, eCL_LEN_4 = 2'b11} t_ccip_clLen;

  typedef struct packed {
    logic [5:0]   rsvd1;
    t_ccip_vc     vc_sel;
    logic         sop;
    logic         rsvd0;
    t_ccip_clLen  cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd2;
    t_ccip_clAddr address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_c1_ReqMemHdr hdr;
    t_ccip_clData       data;
    logic               valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [31:0] rpc_id;
    logic [31:0] arg0;
    logic [31:0] arg1;
  } RpcIf;
endpackage

module ccip_slot_ram #(
  parameter int DATA_WIDTH = 4,
  parameter int ADR_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic [ADR_WIDTH-1:0]  write_address,
  input  logic                  we,
  input  logic [ADR_WIDTH-1:0]  read_address,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [2**ADR_WIDTH];

  // read-before-write: a colliding read returns the old word
  always_ff @(posedge clk) begin
    if (we) mem[write_address] <= d;
    q <= mem[read_address];
  end
endmodule

module ccip_nic_transmitter
  import ccip_nic_pkg::*;
#(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  t_ccip_clAddr                 tx_base_addr,
  input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
  input  logic                         start,
  input  logic                         initialize,
  output logic                         initialized,
  output logic                         error,
  input  logic                         sRx_c1TxAlmFull,
  output t_if_ccip_c1_Tx               sTx_c1,
  output logic                         ccip_tx_ready,
  input  logic [$bits(RpcIf)-1:0]      rpc_in,
  input  logic                         rpc_in_valid,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in
);
  localparam int LF = LMAX_NUM_OF_FLOWS;
  localparam int SW = LMAX_CCIP_BATCH;

  typedef enum logic {S_IDLE, S_CLEAR} t_init_state;

  t_init_state state, state_nxt;
  logic [LF-1:0] clr_addr;
  logic          clr_done;

  logic [1:0]             vld_pipe;
  logic                   accept, flow_ok;
  logic [$bits(RpcIf)-1:0] s1_rpc;
  logic [LF-1:0]          s1_flow, byp_flow;
  logic [SW-1:0]          byp_slot, slot, next_slot, slot_max, ram_q, ram_d;
  logic                   byp_vld, ram_we;
  logic [LF-1:0]          ram_wa;
  t_ccip_c1_ReqMemHdr     hdr_d, hdr_q;
  t_ccip_clData           data_q;

  // init FSM: sweep every flow address once, then hand the write port back
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      clr_addr    <= '0;
      initialized <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_CLEAR) clr_addr <= clr_addr + 1'b1;
      if (clr_done) initialized <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    clr_done  = 1'b0;
    case (state)
      S_IDLE:  if (initialize && !initialized) state_nxt = S_CLEAR;
      S_CLEAR: if (clr_addr == '1) begin
        clr_done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ccip_tx_ready = initialized & start & ~sRx_c1TxAlmFull;
  assign accept        = rpc_in_valid & ccip_tx_ready;
  assign flow_ok       = rpc_flow_id_in <= number_of_flows;

  assign ram_we = (state == S_CLEAR) | vld_pipe[0];
  assign ram_wa = (state == S_CLEAR) ? clr_addr : s1_flow;
  assign ram_d  = (state == S_CLEAR) ? '0 : next_slot;

  ccip_slot_ram #(.DATA_WIDTH(SW), .ADR_WIDTH(LF)) u_slot_ram (
    .clk           (clk),
    .d             (ram_d),
    .write_address (ram_wa),
    .we            (ram_we),
    .read_address  (rpc_flow_id_in),
    .q             (ram_q)
  );

  // the RAM read of a back-to-back same-flow request misses the write still
  // landing this cycle, so forward the previous request's next slot instead
  assign slot      = (byp_vld && byp_flow == s1_flow) ? byp_slot : ram_q;
  assign slot_max  = SW'((32'd1 << l_tx_batch_size) - 32'd1);
  assign next_slot = (slot == slot_max) ? '0 : slot + SW'(1);

  always_comb begin
    hdr_d          = '0;
    hdr_d.req_type = eREQ_WRLINE_I;
    hdr_d.vc_sel   = eVC_VH0;
    hdr_d.cl_len   = eCL_LEN_1;
    hdr_d.sop      = 1'b1;
    hdr_d.address  = tx_base_addr + (t_ccip_clAddr'(s1_flow) << SW) + t_ccip_clAddr'(slot);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      byp_vld  <= 1'b0;
      error    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], accept & flow_ok};
      byp_vld  <= vld_pipe[0];
      if (rpc_in_valid && (!ccip_tx_ready || !flow_ok)) error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    s1_rpc   <= rpc_in;
    s1_flow  <= rpc_flow_id_in;
    byp_flow <= s1_flow;
    byp_slot <= next_slot;
    hdr_q    <= hdr_d;
    data_q   <= t_ccip_clData'(s1_rpc);
  end

  assign sTx_c1 = '{hdr: hdr_q, data: data_q, valid: vld_pipe[1]};
endmodule

// File: tb/tb_ccip_nic_transmitter.sv
// Randomized bench for ccip_nic_transmitter against a per-flow ring-slot model.
module tb_ccip_nic_transmitter;
  import ccip_nic_pkg::*;

  localparam int NIC_ID = 0;
  localparam int LF     = 1;
  localparam int NF     = 2 ** LF;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [LF-1:0]         number_of_flows = '1;
  t_ccip_clAddr          tx_base_addr = '0;
  logic [LMAX_CCIP_BATCH-1:0] l_tx_batch_size = '0;
  logic                  start = 1'b0;
  logic                  initialize = 1'b0;
  logic                  initialized, error;
  logic                  sRx_c1TxAlmFull = 1'b0;
  t_if_ccip_c1_Tx        sTx_c1;
  logic                  ccip_tx_ready;
  logic [$bits(RpcIf)-1:0] rpc_in = '0;
  logic                  rpc_in_valid = 1'b0;
  logic [LF-1:0]         rpc_flow_id_in = '0;

  ccip_nic_transmitter #(.NIC_ID(NIC_ID), .LMAX_NUM_OF_FLOWS(LF)) dut (
    .clk             (clk),
    .reset           (reset),
    .number_of_flows (number_of_flows),
    .tx_base_addr    (tx_base_addr),
    .l_tx_batch_size (l_tx_batch_size),
    .start           (start),
    .initialize      (initialize),
    .initialized     (initialized),
    .error           (error),
    .sRx_c1TxAlmFull (sRx_c1TxAlmFull),
    .sTx_c1          (sTx_c1),
    .ccip_tx_ready   (ccip_tx_ready),
    .rpc_in          (rpc_in),
    .rpc_in_valid    (rpc_in_valid),
    .rpc_flow_id_in  (rpc_flow_id_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    int           flow;
    int           slot;
    t_ccip_clAddr addr;
    logic [95:0]  data;
  } exp_t;

  exp_t         exp_q[$];
  t_ccip_clAddr obs_q[$];
  int           slot_m[NF];
  bit           err_m, init_m;
  int           n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic t_ccip_clAddr obs_at(input int i);
    return (obs_q.size() > i) ? obs_q[i] : '1;
  endfunction

  // one cycle: check outputs due now, drive new inputs, advance the model
  task automatic step(input bit v, input int f, input bit af, input bit st);
    exp_t        e;
    bit          rdy;
    logic [95:0] d;
    @(negedge clk);
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check("wr_valid", sTx_c1.valid, 1);
      check("wr_addr", sTx_c1.hdr.address, e.addr);
      check("wr_data", sTx_c1.data[95:0], e.data);
      check("wr_data_hi", |sTx_c1.data[511:96], 0);
      check("wr_type", sTx_c1.hdr.req_type, eREQ_WRLINE_I);
      check("wr_vc", sTx_c1.hdr.vc_sel, eVC_VH0);
      check("wr_len", sTx_c1.hdr.cl_len, eCL_LEN_1);
      check("wr_sop", sTx_c1.hdr.sop, 1);
      obs_q.push_back(sTx_c1.hdr.address);
      $display("NIC%0d: write flow %0d slot %0d", NIC_ID, e.flow, e.slot);
    end else begin
      check("idle_valid", sTx_c1.valid, 0);
    end
    check("error", error, err_m);
    check("initialized", initialized, init_m);
    d = {$urandom, $urandom, $urandom};
    rpc_in          = d;
    rpc_in_valid    = v;
    rpc_flow_id_in  = LF'(f);
    sRx_c1TxAlmFull = af;
    start           = st;
    #1;
    rdy = init_m && st && !af;
    check("ready", ccip_tx_ready, rdy);
    if (v) begin
      if (!rdy || f > int'(number_of_flows)) err_m = 1'b1;
      else begin
        e.due  = cyc + 2;
        e.flow = f;
        e.slot = slot_m[f];
        e.addr = tx_base_addr + t_ccip_clAddr'(f * (1 << LMAX_CCIP_BATCH) + slot_m[f]);
        e.data = d;
        exp_q.push_back(e);
        slot_m[f] = (slot_m[f] + 1) % (1 << l_tx_batch_size);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset        = 1'b1;
    rpc_in_valid = 1'b0;
    initialize   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", sTx_c1.valid, 0);
    check("rst_initialized", initialized, 0);
    check("rst_error", error, 0);
    reset = 1'b0;
    exp_q.delete();
    err_m  = 1'b0;
    init_m = 1'b0;
  endtask

  task automatic do_init();
    int n;
    @(negedge clk);
    initialize      = 1'b1;
    start           = 1'b1;
    sRx_c1TxAlmFull = 1'b0;
    n = 0;
    while (!initialized && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!initialized) check("ready_pre_init", ccip_tx_ready, 0);
    end
    check("init_latency", n, NF + 1);
    initialize = 1'b0;
    init_m     = 1'b1;
    for (int i = 0; i < NF; i++) slot_m[i] = 0;
  endtask

  initial begin
    int wrap_exp[5];
    wrap_exp = '{0, 1, 2, 3, 0};

    // single write to flow 1
    number_of_flows = 1'b1;
    tx_base_addr    = 42'h1000;
    l_tx_batch_size = 4'd2;
    do_reset();
    do_init();
    obs_q.delete();
    step(1, 1, 0, 1);
    idle(3);
    check("single_cnt", obs_q.size(), 1);
    check("single_addr", obs_at(0), 42'h1010);

    // ring wrap on flow 0
    tx_base_addr = '0;
    do_reset();
    do_init();
    obs_q.delete();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 5; i++) check("wrap_addr", obs_at(i), 42'(wrap_exp[i]));

    // back-to-back same flow
    do_reset();
    do_init();
    obs_q.delete();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1);
    idle(3);
    for (int i = 0; i < 3; i++) check("b2b_addr", obs_at(i), 42'(16 + i));

    // interleaved flows
    do_reset();
    do_init();
    obs_q.delete();
    step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    idle(3);
    check("intlv_addr0", obs_at(0), 42'h00);
    check("intlv_addr1", obs_at(1), 42'h10);
    check("intlv_addr2", obs_at(2), 42'h01);

    // back-pressure drops the RPC and flags error
    obs_q.delete();
    step(1, 0, 1, 1);
    idle(3);
    check("bp_error", error, 1);
    check("bp_nowrite", obs_q.size(), 0);

    // out-of-range flow id
    number_of_flows = 1'b0;
    do_reset();
    do_init();
    obs_q.delete();
    step(1, 1, 0, 1);
    idle(3);
    check("badflow_error", error, 1);
    check("badflow_nowrite", obs_q.size(), 0);
    step(1, 0, 0, 1);
    idle(3);
    check("badflow_goodwrite", obs_q.size(), 1);

    // reset with requests in flight, then randomized phases
    step(1, 0, 0, 1);
    for (int p = 0; p < 4; p++) begin
      do_reset();
      number_of_flows = LF'($urandom_range(0, NF - 1));
      tx_base_addr    = {$urandom, $urandom};
      l_tx_batch_size = LMAX_CCIP_BATCH'($urandom_range(0, LMAX_CCIP_BATCH - 1));
      do_init();
      initialize = (p == 0);
      for (int i = 0; i < 200; i++)
        step(($urandom % 10) < 7, int'($urandom % NF), ($urandom % 10) == 0, ($urandom % 10) != 0);
      idle(4);
      check("drain", exp_q.size(), 0);
      step(1, 0, 0, 1);
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
